aclk_alarm_sequencer: RTL and testbench

// Alarm ring/snooze controller for the alarm clock. Compares the current-time counter digits with the

---
 rtl/aclk_pkg.sv | 20 ++
 rtl/aclk_edge_det.sv | 22 ++
 rtl/aclk_alarm_sequencer.sv | 174 +++++++++++++++++
 tb/tb_aclk_alarm_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// aclk_pkg: shared types and constants for the alarm clock blocks.
//   state_t      - alarm sequencer state encoding
//   BCD_W        - width of one BCD time digit
//   DEF_*        - default tick counts for the alarm sequencer
package aclk_pkg;

    localparam int BCD_W = 4;

    localparam int DEF_RING_TIMEOUT_SEC = 60;
    localparam int DEF_SNOOZE_MIN       = 5;
    localparam int DEF_MAX_SNOOZE       = 3;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } state_t;

endpackage

// File: rtl/aclk_edge_det.sv
// aclk_edge_det: rising-edge detector with a registered history bit.
//   clk   in  system clock
//   reset in  synchronous active-high reset (history cleared to 0)
//   d     in  level input
//   rise  out 1 in the cycle d is high and was low the cycle before
module aclk_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/aclk_alarm_sequencer.sv
// aclk_alarm_sequencer: alarm ring/snooze controller.
// Compares current time with the alarm time and sequences the speaker
// output through arm, ring, snooze, re-ring, timeout and stop.
//   clk, reset                   clock, synchronous active-high reset
//   one_second, one_minute       1-cycle ticks from the time generator
//   alarm_on                     alarm enable switch (level)
//   snooze_button, stop_button   button levels; rising edge = request
//   current_time_*, alarm_time_* BCD digits ms_hr, ls_hr, ms_min, ls_min
//   alarm_sound                  beep output, 1 s on / 1 s off while ringing
//   alarm_active                 state is RINGING
//   snooze_active                state is SNOOZE
//   snooze_count                 snoozes used in the current alarm event
module aclk_alarm_sequencer
    import aclk_pkg::*;
#(
    parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC,
    parameter int SNOOZE_MIN       = DEF_SNOOZE_MIN,
    parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE,
    localparam int SC_W            = $clog2(MAX_SNOOZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             one_second,
    input  logic             one_minute,
    input  logic             alarm_on,
    input  logic             snooze_button,
    input  logic             stop_button,
    input  logic [BCD_W-1:0] current_time_ms_hr,
    input  logic [BCD_W-1:0] current_time_ls_hr,
    input  logic [BCD_W-1:0] current_time_ms_min,
    input  logic [BCD_W-1:0] current_time_ls_min,
    input  logic [BCD_W-1:0] alarm_time_ms_hr,
    input  logic [BCD_W-1:0] alarm_time_ls_hr,
    input  logic [BCD_W-1:0] alarm_time_ms_min,
    input  logic [BCD_W-1:0] alarm_time_ls_min,
    output logic             alarm_sound,
    output logic             alarm_active,
    output logic             snooze_active,
    output logic [SC_W-1:0]  snooze_count
);

    localparam int RT_W = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int ST_W = $clog2(SNOOZE_MIN + 1);

    localparam logic [RT_W-1:0] RT_MAX = RT_W'(RING_TIMEOUT_SEC);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(SNOOZE_MIN);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_SNOOZE);

    logic match, alarm_ev, snooze_ev, stop_ev;

    assign match = (current_time_ms_hr  == alarm_time_ms_hr)  &&
                   (current_time_ls_hr  == alarm_time_ls_hr)  &&
                   (current_time_ms_min == alarm_time_ms_min) &&
                   (current_time_ls_min == alarm_time_ls_min);

    // The match edge is the alarm event, so switching alarm_on while the
    // time already matches cannot ring: match_d is tracked regardless of state.
    aclk_edge_det u_match_ed  (.clk(clk), .reset(reset), .d(match),         .rise(alarm_ev));
    aclk_edge_det u_snooze_ed (.clk(clk), .reset(reset), .d(snooze_button), .rise(snooze_ev));
    aclk_edge_det u_stop_ed   (.clk(clk), .reset(reset), .d(stop_button),   .rise(stop_ev));

    state_t          state, state_nxt;
    logic            beep, beep_nxt;
    logic [RT_W-1:0] ring_timer, ring_timer_nxt, ring_inc;
    logic [ST_W-1:0] snooze_timer, snooze_timer_nxt, snooze_inc;
    logic [SC_W-1:0] count_nxt;

    // Saturating increments; the transitions fire at the limit so the
    // saturation only guards against wrap.
    assign ring_inc   = (ring_timer   == RT_MAX) ? ring_timer   : ring_timer   + RT_W'(1);
    assign snooze_inc = (snooze_timer == ST_MAX) ? snooze_timer : snooze_timer + ST_W'(1);

    always_comb begin
        state_nxt        = state;
        beep_nxt         = beep;
        ring_timer_nxt   = ring_timer;
        snooze_timer_nxt = snooze_timer;
        count_nxt        = snooze_count;

        if (!alarm_on) begin
            state_nxt        = DISARMED;
            beep_nxt         = 1'b0;
            ring_timer_nxt   = '0;
            snooze_timer_nxt = '0;
            count_nxt        = '0;
        end else begin
            unique case (state)
                DISARMED: begin
                    state_nxt        = ARMED;
                    beep_nxt         = 1'b0;
                    ring_timer_nxt   = '0;
                    snooze_timer_nxt = '0;
                    count_nxt        = '0;
                end
                ARMED: begin
                    if (alarm_ev) begin
                        state_nxt      = RINGING;
                        ring_timer_nxt = '0;
                        count_nxt      = '0;
                        beep_nxt       = 1'b1;
                    end
                end
                RINGING: begin
                    if (stop_ev || (snooze_ev && snooze_count == SC_MAX)) begin
                        state_nxt        = ARMED;
                        beep_nxt         = 1'b0;
                        ring_timer_nxt   = '0;
                        snooze_timer_nxt = '0;
                        count_nxt        = '0;
                    end else if (snooze_ev) begin
                        state_nxt        = SNOOZE;
                        beep_nxt         = 1'b0;
                        count_nxt        = snooze_count + SC_W'(1);
                        snooze_timer_nxt = '0;
                    end else if (one_second) begin
                        if (ring_inc == RT_MAX) begin
                            state_nxt        = ARMED;
                            beep_nxt         = 1'b0;
                            ring_timer_nxt   = '0;
                            snooze_timer_nxt = '0;
                            count_nxt        = '0;
                        end else begin
                            ring_timer_nxt = ring_inc;
                            beep_nxt       = ~beep;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_ev) begin
                        state_nxt        = ARMED;
                        beep_nxt         = 1'b0;
                        ring_timer_nxt   = '0;
                        snooze_timer_nxt = '0;
                        count_nxt        = '0;
                    end else if (one_minute) begin
                        if (snooze_inc == ST_MAX) begin
                            state_nxt      = RINGING;
                            ring_timer_nxt = '0;
                            beep_nxt       = 1'b1;
                        end else begin
                            snooze_timer_nxt = snooze_inc;
                        end
                    end
                end
                default: state_nxt = DISARMED;
            endcase
        end
    end

    // Outputs are registered from the next-state values so an event in
    // cycle N is visible on the pins in cycle N+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= DISARMED;
            beep          <= 1'b0;
            ring_timer    <= '0;
            snooze_timer  <= '0;
            snooze_count  <= '0;
            alarm_sound   <= 1'b0;
            alarm_active  <= 1'b0;
            snooze_active <= 1'b0;
        end else begin
            state         <= state_nxt;
            beep          <= beep_nxt;
            ring_timer    <= ring_timer_nxt;
            snooze_timer  <= snooze_timer_nxt;
            snooze_count  <= count_nxt;
            alarm_sound   <= (state_nxt == RINGING) && beep_nxt;
            alarm_active  <= (state_nxt == RINGING);
            snooze_active <= (state_nxt == SNOOZE);
        end
    end

endmodule

// File: tb/tb_aclk_alarm_sequencer.sv
// Scoreboard bench for aclk_alarm_sequencer. Stimulus drives one cycle of
// inputs and queues the expected outputs for the following cycle; a
// monitor on the falling edge pops and compares.
module tb_aclk_alarm_sequencer;

    localparam int SC_W = 1;

    logic       clk = 1'b0;
    logic       reset, one_second, one_minute, alarm_on;
    logic       snooze_button, stop_button;
    logic [3:0] c_mh, c_lh, c_mm, c_lm;
    logic [3:0] a_mh, a_lh, a_mm, a_lm;
    logic       alarm_sound, alarm_active, snooze_active;
    logic [SC_W-1:0] snooze_count;

    aclk_alarm_sequencer #(
        .RING_TIMEOUT_SEC(4), .SNOOZE_MIN(2), .MAX_SNOOZE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .one_second(one_second), .one_minute(one_minute),
        .alarm_on(alarm_on),
        .snooze_button(snooze_button), .stop_button(stop_button),
        .current_time_ms_hr(c_mh), .current_time_ls_hr(c_lh),
        .current_time_ms_min(c_mm), .current_time_ls_min(c_lm),
        .alarm_time_ms_hr(a_mh), .alarm_time_ls_hr(a_lh),
        .alarm_time_ms_min(a_mm), .alarm_time_ls_min(a_lm),
        .alarm_sound(alarm_sound), .alarm_active(alarm_active),
        .snooze_active(snooze_active), .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] exp;   // {sound, active, snooze_active, count}
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   assertions = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [3:0] act;
            e   = q.pop_front();
            act = {alarm_sound, alarm_active, snooze_active, snooze_count};
            assertions++;
            if (e.cyc < cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d not checked, now cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got snd/act/snz/cnt=%b required %b (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    // Advance one clock with the inputs currently driven; optionally queue
    // the outputs expected after that edge. Tick pulses are cleared after.
    task automatic step(input bit chk, input logic [3:0] exp, input string name);
        if (chk) q.push_back('{cyc: cyc + 1, exp: exp, name: name});
        @(posedge clk);
        #1;
        one_second = 1'b0;
        one_minute = 1'b0;
    endtask

    task automatic set_min(input logic [3:0] lm);
        c_mh = 4'd0; c_lh = 4'd7; c_mm = 4'd3; c_lm = lm;
    endtask

    // Leave the alarm minute and come back to it to produce a fresh event.
    task automatic ring(input string name);
        set_min(4'd1);
        step(1, 4'b0000, {name, "_pre"});
        set_min(4'd0);
        step(1, 4'b1100, name);
    endtask

    initial begin
        reset = 1'b1; one_second = 0; one_minute = 0; alarm_on = 0;
        snooze_button = 0; stop_button = 0;
        a_mh = 4'd0; a_lh = 4'd7; a_mm = 4'd3; a_lm = 4'd0;
        set_min(4'd9);
        c_mm = 4'd2;                       // 07:29
        #1;
        step(1, 4'b0000, "reset_state");
        step(1, 4'b0000, "reset_hold");

        // 1: ring on 07:29 -> 07:30, beep 1,0,1,0, timeout after 4 ticks
        reset = 1'b0; alarm_on = 1'b1;
        step(1, 4'b0000, "arm");
        step(1, 4'b0000, "armed_idle");
        set_min(4'd0);
        step(1, 4'b1100, "t1_ring");
        step(1, 4'b1100, "t1_hold");
        one_second = 1; step(1, 4'b0100, "t1_sec1");
        one_second = 1; step(1, 4'b1100, "t1_sec2");
        step(1, 4'b1100, "t1_sec2_hold");
        one_second = 1; step(1, 4'b0100, "t1_sec3");
        one_second = 1; step(1, 4'b0000, "t1_timeout");
        step(1, 4'b0000, "t1_no_rering");

        // 2: snooze, re-ring after 2 minutes, second snooze hits the limit
        ring("t2_ring");
        one_minute = 1; step(1, 4'b1100, "t2_min_ignored_ringing");
        snooze_button = 1; step(1, 4'b0011, "t2_snooze");
        step(1, 4'b0011, "t2_snooze_level_held");
        snooze_button = 0; one_minute = 1; step(1, 4'b0011, "t2_min1");
        one_second = 1; step(1, 4'b0011, "t2_sec_in_snooze");
        one_minute = 1; step(1, 4'b1101, "t2_rering");
        snooze_button = 1; step(1, 4'b0000, "t2_snooze_limit");
        snooze_button = 0; step(1, 4'b0000, "t2_armed");
        snooze_button = 1; step(1, 4'b0000, "t2_snooze_in_armed");
        snooze_button = 0;

        // 3: snooze and stop together, stop wins
        ring("t3_ring");
        snooze_button = 1; stop_button = 1; step(1, 4'b0000, "t3_stop_wins");
        snooze_button = 0; stop_button = 0; step(1, 4'b0000, "t3_armed");

        // 4: alarm_on drop while ringing, re-enable while matched
        ring("t4_ring");
        alarm_on = 0; step(1, 4'b0000, "t4_disarm");
        alarm_on = 1; step(1, 4'b0000, "t4_rearm");
        step(1, 4'b0000, "t4_no_ring");
        one_second = 1; step(1, 4'b0000, "t4_no_ring_sec");

        // 5: reset in SNOOZE, no re-ring afterwards
        ring("t5_ring");
        snooze_button = 1; step(1, 4'b0011, "t5_snooze");
        snooze_button = 0; one_minute = 1; step(1, 4'b0011, "t5_min1");
        reset = 1; step(1, 4'b0000, "t5_reset");
        reset = 0; step(1, 4'b0000, "t5_after_reset");
        one_minute = 1; step(1, 4'b0000, "t5_min1_after");
        one_minute = 1; step(1, 4'b0000, "t5_min2_after");
        step(1, 4'b0000, "t5_idle");

        step(0, 4'b0000, "");
        step(0, 4'b0000, "");
        if (q.size() != 0) begin
            assertions++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
